// File: rtl/ccg_lut_eval_misr.sv
// Truth-table evaluator for generated benchmark circuits: one registered lookup per
// accepted vector, valid/ready on both sides, and a MISR over every delivered result.
module ccg_lut_eval_misr #(
  parameter int                N_IN      = 7,
  parameter int                N_OUT     = 2,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'hB400,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [N_IN-1:0]   cfg_addr,
  input  logic [N_OUT-1:0]  cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_f,
  input  logic              sig_clear,
  output logic [MISR_W-1:0] sig,
  output logic [CNT_W-1:0]  vec_count
);

  localparam int ROWS = 1 << N_IN;

  logic [N_OUT-1:0]  tt [ROWS];
  logic              accept;
  logic              deliver;
  logic [MISR_W-1:0] sig_next;

  // A config write blocks acceptance so a lookup never races its own row update.
  assign in_ready = !cfg_we && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  // NOTE: every variable driven in always_comb gets a value on every path, or a latch is inferred.
  always_comb begin
    sig_next = {sig[MISR_W-2:0], 1'b0};
    if (sig[MISR_W-1]) sig_next = sig_next ^ MISR_POLY;
    sig_next = sig_next ^ MISR_W'(out_f);
  end

  // NOTE: the table is reset row by row because the block must read all-zero after reset;
  // this forces flops instead of a RAM macro, which is acceptable at 2^N_IN x N_OUT bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) tt[i] <= '0;
    end else if (cfg_we) begin
      tt[cfg_addr] <= cfg_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_f     <= tt[in_x];
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

  // Clear takes priority so a delivering cycle can still start a fresh signature window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig       <= '0;
      vec_count <= '0;
    end else if (sig_clear) begin
      sig       <= '0;
      vec_count <= '0;
    end else if (deliver) begin
      sig <= sig_next;
      if (vec_count != {CNT_W{1'b1}}) vec_count <= vec_count + 1'b1;
    end
  end

endmodule
